alu_share_arb: RTL and testbench
================================

# alu_share_arb

Two-port arbiter and sequencer that shares one `ALU` instance between two requesters, for example the execute stage and a branch or address unit. Each port uses a valid/ready request channel and a valid/ready response channel. Arbitration is round-robin. Operands are captured into a holding register, evaluated by the single combinational `ALU`, and the result `C`/`br` is presented to the owning port until that port accepts it. Sustained throughput is one operation per cycle.

## Interface
- `CNT_W`, default 16: width of the per-port grant counters.
- `cpu_clk` in, 1: sole clock; all state updates on the rising edge.
- `cpu_rst` in, 1: asynchronous, active-high reset.
- `req0_valid` in, 1: port 0 request valid.
- `req0_ready` out, 1: port 0 request accepted this cycle when high together with `req0_valid`.
- `req0_op` in, 4: ALU op code, same encoding as `alu_op`.
- `req0_a` in, 32: operand A.
- `req0_b` in, 32: operand B.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`: port 1, identical meaning.
- `rsp0_valid` out, 1: result held for port 0.
- `rsp0_ready` in, 1: port 0 accepts the result.
- `rsp1_valid` out, 1: result held for port 1.
- `rsp1_ready` in, 1: port 1 accepts the result.
- `rsp_c` out, 32: held operation result; shared by both ports and qualified by `rspN_valid`.
- `rsp_br` out, 1: held compare/branch flag; qualified the same way.
- `grant_cnt0` out, CNT_W: number of accepted port 0 requests; wraps modulo 2^CNT_W.
- `grant_cnt1` out, CNT_W: same, for port 1.

## Operation
- Internal state:
  - `slot_full` (result held).
  - `owner` (0/1).
  - Operand registers `op_q`, `a_q`, `b_q`.
  - `last_grant` (0/1).
  - Two counters.
- The `ALU` instance is driven only from `op_q`, `a_q`, `b_q`. Its `C` and `br` outputs drive `rsp_c` and `rsp_br` directly. Latency therefore depends only on the registers.
- `slot_free = !slot_full | (rsp_owner_valid & rsp_owner_ready)`. The slot is free if it is empty, or if the held result is handshaken this cycle.
- Arbitration is combinational and is evaluated only when `slot_free`:
  - Only one port valid: that port is granted.
  - Both ports valid: the port that is not `last_grant` is granted.
  - Neither port valid: no grant.
- `reqN_ready = slot_free & (grant == N)`. Ready is never high for both ports in the same cycle. When `slot_free` is 0, both ready signals are 0.
- Ready may depend combinationally on the other port's valid and on the current owner's `rsp_ready`. Requesters must not make valid depend on ready.
- On a request handshake:
  - Capture `op`, `a`, `b`.
  - Set `owner` to the granted port and `slot_full` to 1.
  - Update `last_grant`.
  - Increment that port's counter.
- On a response handshake with no new request: `slot_full` goes to 0.
- Response and new request in the same cycle: `slot_full` stays 1 and the registers take the new request. This is back-to-back operation.
- `rspN_valid = slot_full & (owner == N)`. The non-owner's `rsp_ready` is ignored.
- The ALU is combinational, so `rsp_c` and `rsp_br` hold steady while `slot_full`, because the operand registers are frozen.
- Op codes outside the defined `alu_op` set are forbidden at the request port. The output for them is undefined, and the bench treats them as an error.
- Reset mid-operation:
  - The held result is discarded without a response.
  - The grant counters clear.
  - Requesters must reissue.

## Timing
- Reset values:
  - `rsp0_valid` = 0, `rsp1_valid` = 0.
  - `slot_full` = 0, `owner` = 0.
  - `last_grant` = 1, so port 0 wins the first tie.
  - `op_q` = ALU_ADD, `a_q` = 0, `b_q` = 0; hence `rsp_c` = 0 and `rsp_br` = 0.
  - `grant_cnt0` = 0, `grant_cnt1` = 0.
  - `req0_ready` and `req1_ready` are combinational. They are 0 while `cpu_rst` is high; after reset they follow the arbitration rule.
- Latency:
  - A request accepted at edge k produces `rspN_valid` = 1 after edge k, with a valid result in cycle k+1.
  - If `rspN_ready` = 1 in cycle k+1, the result retires at edge k+1.
- Throughput: one accept per cycle when the owner keeps `rsp_ready` high.
- Fairness: with both ports continuously valid and ready, grants alternate 0,1,0,1…
- Backpressure: with the owner's `rsp_ready` = 0, both `req_ready` stay 0 and the result and operands hold indefinitely.
- Counter wrap: 2^CNT_W − 1 + 1 → 0, with no flag.

## Test plan
- Single op, port 0: after reset, send `op` = ADD, A = 5, B = 7 with `rsp0_ready` = 1. Required:
  - `req0_ready` = 1 in the same cycle.
  - `rsp0_valid` = 1 one cycle later, with `rsp_c` = 12.
  - `rsp1_valid` = 0.
  - `grant_cnt0` = 1.
- Tie and round-robin: both ports valid for 4 cycles with ops ADD and SUB, both `rsp_ready` = 1. Required:
  - Grant order 0,1,0,1.
  - Back-to-back responses with no bubble.
  - Each counter = 2.
- Backpressure: port 1 sends SCMP with A = 0xFFFFFFFF, B = 1, and holds `rsp1_ready` = 0 for 5 cycles while port 0 stays valid. Required:
  - `rsp_c` = 1 and `rsp_br` = 1, held for all 5 cycles.
  - `req0_ready` = 0 throughout.
  - Port 0 is granted in the cycle `rsp1_ready` rises.
- Branch flag: SUB with A = B = 0x1234 gives `rsp_br` = 1 and `rsp_c` = 0. UCMP with A = 0xFFFFFFFF, B = 1 gives `rsp_br` = 0 and `rsp_c` = 0.
- Reset mid-operation: a result is held with `rsp0_ready` = 0, then `cpu_rst` pulses asynchronously (between edges). Required:
  - `rsp0_valid` drops immediately.
  - Counters = 0.
  - The next tie grants port 0.
- Counter wrap with CNT_W = 4: 17 port 0 ops leave `grant_cnt0` = 1.

Source files
------------

// File: rtl/alu_share_arb_if.sv
// Request/response bundle for the shared-ALU arbiter: two valid/ready request
// channels, two valid/ready response channels, the shared result and the grant counters.
interface alu_share_arb_if #(
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_op;
  logic [31:0]      req0_a;
  logic [31:0]      req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_op;
  logic [31:0]      req1_a;
  logic [31:0]      req1_b;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [31:0]      rsp_c;
  logic             rsp_br;
  logic [CNT_W-1:0] grant_cnt0;
  logic [CNT_W-1:0] grant_cnt1;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_c, rsp_br, grant_cnt0, grant_cnt1
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_c, rsp_br, grant_cnt0, grant_cnt1
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One result slot; a response and a new request may handshake in the same cycle.
module alu_share_arb #(
  parameter int CNT_W = 16
) (
  input logic           cpu_clk,
  input logic           cpu_rst,
  alu_share_arb_if.slave bus
);
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SCMP = 4'd8;
  localparam logic [3:0] ALU_UCMP = 4'd9;

  typedef enum logic [1:0] {S_EMPTY, S_HOLD0, S_HOLD1} slot_e;

  slot_e            state_q, state_d;
  logic             slot_full, owner, last_grant;
  logic             rsp_hs, slot_free, gnt_vld, gnt_port, req_hs;
  logic [3:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;
  logic [32:0]      alu_res;

  // Returns {br, C}. br is the equality flag for SUB and the less-than flag for compares.
  function automatic logic [32:0] alu_eval(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0]        c;
    logic               br;
    sa = a;
    sb = b;
    c  = '0;
    br = 1'b0;
    case (op)
      ALU_ADD:  c = a + b;
      ALU_SUB:  begin c = a - b; br = (c == 32'd0); end
      ALU_AND:  c = a & b;
      ALU_OR:   c = a | b;
      ALU_XOR:  c = a ^ b;
      ALU_SLL:  c = a << b[4:0];
      ALU_SRL:  c = a >> b[4:0];
      ALU_SRA:  c = sa >>> b[4:0];
      ALU_SCMP: begin br = (sa < sb); c = {31'd0, br}; end
      ALU_UCMP: begin br = (a < b);   c = {31'd0, br}; end
      default:  c = '0;
    endcase
    return {br, c};
  endfunction

  assign slot_full = (state_q != S_EMPTY);
  assign owner     = (state_q == S_HOLD1);
  assign rsp_hs    = slot_full & (owner ? bus.rsp1_ready : bus.rsp0_ready);
  assign slot_free = !slot_full | rsp_hs;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_port = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_vld  = 1'b1;
      gnt_port = ~last_grant;
    end else if (bus.req0_valid) begin
      gnt_vld  = 1'b1;
    end else if (bus.req1_valid) begin
      gnt_vld  = 1'b1;
      gnt_port = 1'b1;
    end
  end

  assign req_hs         = slot_free & gnt_vld & !cpu_rst;
  assign bus.req0_ready = req_hs & !gnt_port;
  assign bus.req1_ready = req_hs & gnt_port;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) state_q <= S_EMPTY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (req_hs)      state_d = gnt_port ? S_HOLD1 : S_HOLD0;
    else if (rsp_hs) state_d = S_EMPTY;
  end

  // Operand capture and grant bookkeeping
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      op_q       <= ALU_ADD;
      a_q        <= '0;
      b_q        <= '0;
      last_grant <= 1'b1;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else if (req_hs) begin
      op_q       <= gnt_port ? bus.req1_op : bus.req0_op;
      a_q        <= gnt_port ? bus.req1_a  : bus.req0_a;
      b_q        <= gnt_port ? bus.req1_b  : bus.req0_b;
      last_grant <= gnt_port;
      if (gnt_port) cnt1_q <= cnt1_q + 1'b1;
      else          cnt0_q <= cnt0_q + 1'b1;
    end
  end

  // Result path: combinational ALU straight off the frozen operand registers
  assign alu_res        = alu_eval(op_q, a_q, b_q);
  assign bus.rsp_c      = alu_res[31:0];
  assign bus.rsp_br     = alu_res[32];
  assign bus.rsp0_valid = slot_full & !owner;
  assign bus.rsp1_valid = slot_full & owner;
  assign bus.grant_cnt0 = cnt0_q;
  assign bus.grant_cnt1 = cnt1_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed table, multi-cycle corner sequences and a
// randomized run checked each cycle against a slot/queue-level reference model.
module tb_alu_share_arb;
  localparam int CNT_W = 4;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
                         SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, SCMP = 4'd8, UCMP = 4'd9;

  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b1;
  always #5 cpu_clk = ~cpu_clk;

  alu_share_arb_if #(.CNT_W(CNT_W)) bus ();
  alu_share_arb #(.CNT_W(CNT_W)) dut (.cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .bus(bus));

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        br;
  } alu_vec_t;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int          m_full, m_owner, m_last, m_cnt0, m_cnt1;
  logic [31:0] m_c;
  logic        m_br;

  // per-cycle snapshots taken at the sampling edge
  int          acc_port;
  logic        s_rdy0, s_v0, s_v1, s_br;
  logic [31:0] s_c;
  int          s_cnt0, s_cnt1;

  function automatic logic [32:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    logic [31:0] c;
    logic        br;
    int          s;
    s  = int'(b & 32'd31);
    c  = 32'd0;
    br = 1'b0;
    case (op)
      ADD:  c = a + b;
      SUB:  begin c = a + (~b) + 32'd1; br = (a == b); end
      AND_: c = a & b;
      OR_:  c = a | b;
      XOR_: c = a ^ b;
      SLL:  c = a << s;
      SRL:  c = a >> s;
      SRA:  c = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      SCMP: begin br = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000); c = {31'd0, br}; end
      UCMP: begin br = (a < b); c = {31'd0, br}; end
      default: c = 32'd0;
    endcase
    return {br, c};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_owner = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
    m_c = 32'd0; m_br = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_op = ADD; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = ADD; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  // One clock: compare everything at the falling edge, then advance the model.
  task automatic step();
    int          g;
    logic        rh, free;
    logic [3:0]  op;
    logic [31:0] a, b;
    @(negedge cpu_clk);
    rh   = (m_full != 0) && ((m_owner == 0) ? bus.rsp0_ready : bus.rsp1_ready);
    free = (m_full == 0) || rh;
    if (bus.req0_valid && bus.req1_valid) g = 1 - m_last;
    else if (bus.req0_valid)              g = 0;
    else if (bus.req1_valid)              g = 1;
    else                                  g = -1;
    if (!free) g = -1;
    check("req0_ready", bus.req0_ready, g == 0);
    check("req1_ready", bus.req1_ready, g == 1);
    check("rsp0_valid", bus.rsp0_valid, (m_full != 0) && (m_owner == 0));
    check("rsp1_valid", bus.rsp1_valid, (m_full != 0) && (m_owner == 1));
    check("rsp_c", bus.rsp_c, m_c);
    check("rsp_br", bus.rsp_br, m_br);
    check("grant_cnt0", bus.grant_cnt0, m_cnt0);
    check("grant_cnt1", bus.grant_cnt1, m_cnt1);
    s_rdy0 = bus.req0_ready; s_v0 = bus.rsp0_valid; s_v1 = bus.rsp1_valid;
    s_c = bus.rsp_c; s_br = bus.rsp_br;
    s_cnt0 = int'(bus.grant_cnt0); s_cnt1 = int'(bus.grant_cnt1);
    acc_port = g;
    op = (g == 1) ? bus.req1_op : bus.req0_op;
    a  = (g == 1) ? bus.req1_a  : bus.req0_a;
    b  = (g == 1) ? bus.req1_b  : bus.req0_b;
    @(posedge cpu_clk);
    if (g >= 0) begin
      m_full = 1; m_owner = g; m_last = g;
      {m_br, m_c} = ref_alu(op, a, b);
      if (g == 0) m_cnt0 = (m_cnt0 + 1) % (1 << CNT_W);
      else        m_cnt1 = (m_cnt1 + 1) % (1 << CNT_W);
    end else if (rh) begin
      m_full = 0;
    end
    #1;
  endtask

  // Synchronous-looking reset pulse; readies must stay low while it is held.
  task automatic do_reset();
    @(posedge cpu_clk);
    #2 cpu_rst = 1'b1;
    idle_inputs();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    check("rst_req0_ready", bus.req0_ready, 1'b0);
    check("rst_req1_ready", bus.req1_ready, 1'b0);
    model_reset();
    @(posedge cpu_clk);
    idle_inputs();
    #2 cpu_rst = 1'b0;
  endtask

  alu_vec_t tbl[11];
  int       order[$];

  initial begin
    idle_inputs();
    model_reset();
    acc_port = -1;

    tbl[0]  = '{ADD,  32'd5,          32'd7,          32'd12,         1'b0};
    tbl[1]  = '{SUB,  32'h0000_1234,  32'h0000_1234,  32'd0,          1'b1};
    tbl[2]  = '{UCMP, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    tbl[3]  = '{SCMP, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b1};
    tbl[4]  = '{AND_, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0};
    tbl[5]  = '{OR_,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0,  1'b0};
    tbl[6]  = '{XOR_, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0,  1'b0};
    tbl[7]  = '{SLL,  32'd1,          32'd31,         32'h8000_0000,  1'b0};
    tbl[8]  = '{SRL,  32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0};
    tbl[9]  = '{SRA,  32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0};
    tbl[10] = '{SUB,  32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0};

    // reset values
    do_reset();
    step();
    check("reset_rsp_c", s_c, 32'd0);
    check("reset_rsp0_valid", s_v0, 1'b0);

    // single op on port 0
    bus.req0_valid = 1'b1; bus.req0_op = ADD; bus.req0_a = 32'd5; bus.req0_b = 32'd7;
    bus.rsp0_ready = 1'b1;
    step();
    check("single_req0_ready", s_rdy0, 1'b1);
    bus.req0_valid = 1'b0;
    step();
    check("single_rsp0_valid", s_v0, 1'b1);
    check("single_rsp1_valid", s_v1, 1'b0);
    check("single_rsp_c", s_c, 32'd12);
    check("single_cnt0", s_cnt0, 1);

    // ALU table through port 0
    foreach (tbl[i]) begin
      bus.req0_valid = 1'b1; bus.req0_op = tbl[i].op;
      bus.req0_a = tbl[i].a; bus.req0_b = tbl[i].b; bus.rsp0_ready = 1'b1;
      step();
      bus.req0_valid = 1'b0;
      step();
      check($sformatf("tbl%0d_c", i), s_c, tbl[i].c);
      check($sformatf("tbl%0d_br", i), s_br, tbl[i].br);
    end

    // tie and round-robin, back-to-back
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_op = ADD; bus.req0_a = 32'd10; bus.req0_b = 32'd1;
    bus.req1_valid = 1'b1; bus.req1_op = SUB; bus.req1_a = 32'd10; bus.req1_b = 32'd1;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_grant", acc_port, i % 2);
      if (i > 0) check("rr_no_bubble", s_v0 | s_v1, 1'b1);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    step();
    check("rr_last_rsp", s_v1, 1'b1);
    check("rr_cnt0", s_cnt0, 2);
    check("rr_cnt1", s_cnt1, 2);

    // backpressure on port 1 while port 0 waits
    do_reset();
    bus.req1_valid = 1'b1; bus.req1_op = SCMP; bus.req1_a = 32'hFFFF_FFFF; bus.req1_b = 32'd1;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b0;
    step();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = ADD; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_req0_ready", s_rdy0, 1'b0);
      check("bp_rsp_c", s_c, 32'd1);
      check("bp_rsp_br", s_br, 1'b1);
    end
    bus.rsp1_ready = 1'b1;
    step();
    check("bp_release_grant", acc_port, 0);
    bus.req0_valid = 1'b0;
    step();
    check("bp_after_c", s_c, 32'd2);

    // asynchronous reset while a result is held
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_op = ADD; bus.req0_a = 32'd2; bus.req0_b = 32'd3;
    bus.rsp0_ready = 1'b0;
    step();
    bus.req0_valid = 1'b0;
    step();
    check("midrst_held", s_v0, 1'b1);
    #2 cpu_rst = 1'b1;
    #1;
    check("midrst_rsp0_valid", bus.rsp0_valid, 1'b0);
    check("midrst_cnt0", bus.grant_cnt0, 0);
    check("midrst_rsp_c", bus.rsp_c, 32'd0);
    model_reset();
    @(posedge cpu_clk);
    #2 cpu_rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.rsp0_ready = 1'b1;
    step();
    check("midrst_tie_grant", acc_port, 0);
    idle_inputs();
    step();

    // counter wrap (CNT_W = 4): 17 port-0 ops
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_op = ADD; bus.rsp0_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.req0_a = i; bus.req0_b = 32'd100;
      step();
    end
    bus.req0_valid = 1'b0;
    step();
    check("wrap_cnt0", s_cnt0, 1);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bus.req0_valid = ($urandom_range(0, 3) != 0);
      bus.req1_valid = ($urandom_range(0, 2) != 0);
      bus.req0_op = 4'($urandom_range(0, 9));
      bus.req1_op = 4'($urandom_range(0, 9));
      bus.req0_a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      bus.req0_b = ($urandom_range(0, 3) == 0) ? bus.req0_a : $urandom;
      bus.req1_a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      bus.req1_b = ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom;
      bus.rsp0_ready = ($urandom_range(0, 3) != 0);
      bus.rsp1_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
